// File: rtl/pacman_uart_pkg.sv
// Shared definitions for the Pac-Man board UART (transmitter FSM states, baud divider, frame format).
// UART_TX_PARITY_EN adds the PARITY state and switches frames to 8E1.
package pacman_uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int FRAME_BITS = 10;
`endif

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clock cycles per bit; integer division truncates, matching the receiver.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/pacman_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read port and occupancy count.
module pacman_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  output logic [7:0]  pop_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pacman_uart_tx.sv
// Telemetry UART transmitter: byte FIFO feeding an 8N1 serializer with a registered tx line.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit after the data bits).
module pacman_uart_tx
  import pacman_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);

  tx_state_t     state;
  tx_state_t     next_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tx_q;
  logic          tx_next;
  logic          bit_end;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  pacman_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign tx_ready = ~fifo_full;
  assign tx       = tx_q;
  assign busy     = (state != IDLE) | (level != '0);
  assign bit_end  = (baud_cnt == CW'(DIV - 1));

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) next_state = DATA;
      end
      DATA: begin
        tx_next = shift[0];
        if (bit_end && bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_q;
        if (bit_end) next_state = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit so queued bytes leave without an idle gap.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state <= next_state;
      tx_q  <= tx_next;
      if (bit_end || next_state != state || state == IDLE) baud_cnt <= '0;
      else                                                 baud_cnt <= baud_cnt + CW'(1);
      if (pop) begin
        shift   <= fifo_head;
        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^fifo_head;
`endif
      end else if (state == DATA && bit_end) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pacman_uart_tx.sv
// Self-checking bench for pacman_uart_tx: frame-level reference model plus directed literal frame checks.
module tb_pacman_uart_tx;
  import pacman_uart_pkg::calc_div;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 125_000;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [4:0] level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pacman_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Model: a queue of accepted bytes and one frame in flight, tracked by cycle offset into the frame.
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  bit         m_valid  = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       exp_tx   = 1'b1;

  always @(posedge clk) begin : model
    int pre_size;
    if (rst) begin
      q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      exp_tx   = 1'b1;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      pre_size = q.size();
      exp_tx   = m_active ? frame_bit(m_byte, m_pos / DIV) : 1'b1;
      if (m_active && m_pos < FLEN*DIV - 1) begin
        m_pos++;
      end else if (pre_size > 0) begin
        m_byte   = q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else begin
        m_active = 1'b0;
      end
      if (tx_valid && pre_size < DEPTH) q.push_back(tx_data);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_tx",    32'(tx),       32'(exp_tx));
      checkOutput("model_level", 32'(level),    32'(q.size()));
      checkOutput("model_ready", 32'(tx_ready), 32'(q.size() != DEPTH));
      checkOutput("model_busy",  32'(busy),     32'(m_active || q.size() != 0));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      waitCycles(1);
      n++;
    end
    checkOutput("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit v);
    tx_data  = b;
    tx_valid = v;
    waitCycles(1);
  endtask

  // Send one byte from idle and sample each bit mid-period against a hand-written bit pattern.
  task automatic checkFrame(input logic [7:0] b, input logic [10:0] eb);
    waitIdle(4000);
    applyStimulus(b, 1'b1);
    tx_valid = 1'b0;
    checkOutput("hs_level", 32'(level), 32'(1));
    waitCycles(1);
    checkOutput("tx_before_fall", 32'(tx), 32'(1));
    waitCycles(1);
    checkOutput("tx_fall", 32'(tx), 32'(0));
    waitCycles(DIV/2);
    for (int k = 0; k < FLEN; k++) begin
      checkOutput($sformatf("frame_%02h_bit%0d", b, k), 32'(tx), 32'(eb[k]));
      if (k < FLEN-1) waitCycles(DIV);
    end
    waitCycles(DIV - 2 - DIV/2);
    checkOutput("busy_last_stop", 32'(busy), 32'(1));
    waitCycles(1);
    checkOutput("busy_drop", 32'(busy), 32'(0));
  endtask

  initial begin
    logic [10:0] eb;
    waitCycles(3);
    checkOutput("rst_tx",    32'(tx),       32'(1));
    checkOutput("rst_ready", 32'(tx_ready), 32'(1));
    checkOutput("rst_busy",  32'(busy),     32'(0));
    checkOutput("rst_level", 32'(level),    32'(0));
    rst = 1'b0;
    checkOutput("div_default", 32'(calc_div(100_000_000, 115200)), 32'(868));

`ifdef UART_TX_PARITY_EN
    eb = 11'b10010101010; checkFrame(8'h55, eb);
    eb = 11'b11000001110; checkFrame(8'h07, eb);
    eb = 11'b10000000110; checkFrame(8'h03, eb);
`else
    eb = 11'b01010101010; checkFrame(8'h55, eb);
    eb = 11'b01000001110; checkFrame(8'h07, eb);
    eb = 11'b01000000110; checkFrame(8'h03, eb);
`endif

    // Burst of 17 bytes with valid held; then keep valid high on a full FIFO with changing data.
    waitIdle(4000);
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1);
    checkOutput("burst_level_full", 32'(level),    32'(16));
    checkOutput("burst_ready_low",  32'(tx_ready), 32'(0));
    for (int i = 0; i < 40; i++) applyStimulus(8'($urandom), 1'b1);
    tx_valid = 1'b0;
    checkOutput("full_hold_level", 32'(level), 32'(16));
    waitIdle(17*FLEN*DIV + 100);

    // Push on the same edge the FSM pops the only queued byte.
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    tx_valid = 1'b0;
    checkOutput("coincide_level", 32'(level), 32'(1));
    waitIdle(3*FLEN*DIV + 100);

    // Reset in the middle of data bit 3 with four bytes still queued.
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 1'b1);
    tx_valid = 1'b0;
    checkOutput("pre_reset_level", 32'(level), 32'(4));
    waitCycles(4*DIV + DIV/2 - 2);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("abort_tx",    32'(tx),       32'(1));
    checkOutput("abort_level", 32'(level),    32'(0));
    checkOutput("abort_busy",  32'(busy),     32'(0));
    checkOutput("abort_ready", 32'(tx_ready), 32'(1));
    waitCycles(3*FLEN*DIV);
    checkOutput("abort_quiet", 32'(tx), 32'(1));

    // Random traffic with varying density and rare resets.
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      dens = $urandom_range(0, 4);
      for (int c = 0; c < 250; c++) begin
        rst = ($urandom_range(0, 999) == 0);
        applyStimulus(8'($urandom), $urandom_range(0, 3) < dens);
      end
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    waitIdle(DEPTH*FLEN*DIV + 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
